// File: rtl/sprite_blitter_pkg.sv
// Shared graphics types for the sprite blitter: frame-buffer geometry, pixel and
// coordinate types, blit FSM states, and the clip / linear-address helpers.
package kof_gfx_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;

    typedef logic [ADDR_W-1:0]  fb_addr_t;
    typedef logic [DATA_W-1:0]  pix_t;
    typedef logic signed [10:0] scoord_t;

    localparam pix_t    TRANSPARENT = 8'h00;
    localparam scoord_t FB_WIDTH_S  = scoord_t'(FB_WIDTH);
    localparam scoord_t FB_HEIGHT_S = scoord_t'(FB_HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } blit_state_t;

    function automatic logic in_bounds(input scoord_t dx, input scoord_t dy);
        return (dx >= 11'sd0) && (dx < FB_WIDTH_S) && (dy >= 11'sd0) && (dy < FB_HEIGHT_S);
    endfunction

    // y*320 + x built from shifts; sign-extended so off-screen values stay harmless.
    function automatic fb_addr_t fb_linear_addr(input scoord_t dx, input scoord_t dy);
        fb_addr_t dx_a;
        fb_addr_t dy_a;
        dx_a = {{(ADDR_W-11){dx[10]}}, dx};
        dy_a = {{(ADDR_W-11){dy[10]}}, dy};
        return (dy_a << 4'd8) + (dy_a << 4'd6) + dx_a;
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Command, sprite-ROM and frame-buffer signals of the sprite blitter.
// Optional HFLIP_EN adds the horizontal-flip command bit.
interface sprite_blitter_if;
    import kof_gfx_pkg::*;

    logic       start;
    logic [9:0] spr_x;
    logic [9:0] spr_y;
    logic [8:0] spr_w;
    logic [8:0] spr_h;
    fb_addr_t   spr_base;
`ifdef HFLIP_EN
    logic       flip;
`endif
    fb_addr_t   rom_addr;
    pix_t       rom_data;
    logic       fb_we;
    fb_addr_t   fb_addr;
    pix_t       fb_data;
    logic       busy;
    logic       done;

`ifdef HFLIP_EN
    modport master (
        input  start, spr_x, spr_y, spr_w, spr_h, spr_base, flip, rom_data,
        output rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
    modport slave (
        output start, spr_x, spr_y, spr_w, spr_h, spr_base, flip, rom_data,
        input  rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
`else
    modport master (
        input  start, spr_x, spr_y, spr_w, spr_h, spr_base, rom_data,
        output rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
    modport slave (
        output start, spr_x, spr_y, spr_w, spr_h, spr_base, rom_data,
        input  rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
`endif

endinterface

// File: rtl/sprite_blitter_addr_gen.sv
// Pixel walker for the blitter: latches the sprite arguments, steps col/row and the
// running ROM address, and forms the signed destination coordinate (HFLIP_EN mirrors dx).
module blit_addr_gen
    import kof_gfx_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic       step,
    input  logic [9:0] spr_x,
    input  logic [9:0] spr_y,
    input  logic [8:0] spr_w,
    input  logic [8:0] spr_h,
    input  fb_addr_t   spr_base,
`ifdef HFLIP_EN
    input  logic       flip,
`endif
    output fb_addr_t   rom_addr,
    output scoord_t    dx,
    output scoord_t    dy,
    output logic       last
);

    scoord_t    x_r;
    scoord_t    y_r;
    logic [8:0] w_r;
    logic [8:0] h_r;
    logic [8:0] col_r;
    logic [8:0] row_r;
    fb_addr_t   rom_addr_r;
    logic [8:0] col_eff_s;

    // Argument latch and raster walk; row-major storage makes the ROM address a plain +1.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_r        <= 11'sd0;
            y_r        <= 11'sd0;
            w_r        <= 9'd0;
            h_r        <= 9'd0;
            col_r      <= 9'd0;
            row_r      <= 9'd0;
            rom_addr_r <= 19'd0;
        end else if (load) begin
            x_r        <= {spr_x[9], spr_x};
            y_r        <= {spr_y[9], spr_y};
            w_r        <= spr_w;
            h_r        <= spr_h;
            col_r      <= 9'd0;
            row_r      <= 9'd0;
            rom_addr_r <= spr_base;
        end else if (step) begin
            rom_addr_r <= rom_addr_r + 19'd1;
            if (col_r == w_r - 9'd1) begin
                col_r <= 9'd0;
                row_r <= row_r + 9'd1;
            end else begin
                col_r <= col_r + 9'd1;
            end
        end
    end

`ifdef HFLIP_EN
    logic flip_r;

    // Flip is part of the latched command.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flip_r <= 1'b0;
        end else if (load) begin
            flip_r <= flip;
        end
    end

    assign col_eff_s = flip_r ? (w_r - 9'd1 - col_r) : col_r;
`else
    assign col_eff_s = col_r;
`endif

    assign rom_addr = rom_addr_r;
    assign dx       = x_r + scoord_t'({2'b00, col_eff_s});
    assign dy       = y_r + scoord_t'({2'b00, row_r});
    assign last     = (col_r == w_r - 9'd1) && (row_r == h_r - 9'd1);

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter top: copies a WxH sprite from ROM into the 320x240 frame buffer with
// per-pixel clipping and transparency. Define HFLIP_EN to add horizontal flip.
module sprite_blitter
    import kof_gfx_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    sprite_blitter_if.master bus
);

    blit_state_t state_r;
    logic        busy_r;
    logic        done_r;
    logic        load_s;
    logic        step_s;
    logic        last_s;
    fb_addr_t    rom_addr_s;
    scoord_t     dx_s;
    scoord_t     dy_s;
    logic        valid_d_r;
    logic        inb_d_r;
    fb_addr_t    addr_d_r;
    logic        fb_we_r;
    fb_addr_t    fb_addr_r;
    pix_t        fb_data_r;

    assign load_s = (state_r == IDLE) && bus.start;
    assign step_s = (state_r == RUN) && !last_s;

    blit_addr_gen u_addr_gen (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (load_s),
        .step     (step_s),
        .spr_x    (bus.spr_x),
        .spr_y    (bus.spr_y),
        .spr_w    (bus.spr_w),
        .spr_h    (bus.spr_h),
        .spr_base (bus.spr_base),
`ifdef HFLIP_EN
        .flip     (bus.flip),
`endif
        .rom_addr (rom_addr_s),
        .dx       (dx_s),
        .dy       (dy_s),
        .last     (last_s)
    );

    // Blit sequencer; done is raised on leaving FIN so it appears alongside busy falling.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r  <= 1'b1;
                        state_r <= ((bus.spr_w != 9'd0) && (bus.spr_h != 9'd0)) ? RUN : FIN;
                    end
                end
                RUN: begin
                    if (last_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_r <= FIN;
                end
                FIN: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Coordinate stage waits one clock for ROM data, then the write is registered out.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_d_r <= 1'b0;
            inb_d_r   <= 1'b0;
            addr_d_r  <= 19'd0;
            fb_we_r   <= 1'b0;
            fb_addr_r <= 19'd0;
            fb_data_r <= 8'h00;
        end else begin
            valid_d_r <= (state_r == RUN);
            inb_d_r   <= in_bounds(dx_s, dy_s);
            addr_d_r  <= fb_linear_addr(dx_s, dy_s);
            fb_we_r   <= valid_d_r && inb_d_r && (bus.rom_data != TRANSPARENT);
            fb_addr_r <= addr_d_r;
            fb_data_r <= bus.rom_data;
        end
    end

    assign bus.rom_addr = rom_addr_s;
    assign bus.fb_we    = fb_we_r;
    assign bus.fb_addr  = fb_addr_r;
    assign bus.fb_data  = fb_data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of blits scored against a reference
// write list, plus reset-mid-blit and start-while-busy sequences (flip case with HFLIP_EN).
module tb_sprite_blitter;
    import kof_gfx_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_blitter_if bus();
    sprite_blitter dut (.Clk(clk), .Reset(rst), .bus(bus));

    pix_t rom_mem [0:1023];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr[9:0]];

    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        string name;
        int    x, y, w, h, base;
        bit    pat;
        int    fill, hole;
        bit    flip, poke;
        int    exp_writes, exp_done, exp_first;
    } vec_t;

`ifdef HFLIP_EN
    localparam int NV = 11;
`else
    localparam int NV = 10;
`endif

    vec_t vt [NV];
    wr_t  sb [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   first_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; any frame-buffer write seen here is scored against the expected list.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (bus.fb_we !== 1'b0) begin
            wr_count++;
            if (first_cyc < 0) first_cyc = cyc;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", bus.fb_addr, bus.fb_data);
            end else begin
                e = sb.pop_front();
                if (bus.fb_addr !== e.addr || bus.fb_data !== e.data) begin
                    n_err++;
                    $display("FAIL write: got addr %0d data %0h, expected addr %0d data %0h", bus.fb_addr, bus.fb_data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic load_rom(input vec_t v);
        for (int i = 0; i < 1024; i++) rom_mem[i] = v.pat ? pix_t'((i % 7) + 1) : pix_t'(v.fill);
        if (v.hole >= 0) rom_mem[v.hole] = 8'h00;
    endtask

    // Reference model: raster order, clip, skip transparent.
    task automatic build_expect(input vec_t v);
        sb.delete();
        for (int r = 0; r < v.h; r++) begin
            for (int c = 0; c < v.w; c++) begin
                int   dx, dy;
                pix_t d;
                wr_t  e;
`ifdef HFLIP_EN
                dx = v.flip ? (v.x + v.w - 1 - c) : (v.x + c);
`else
                dx = v.x + c;
`endif
                dy = v.y + r;
                d  = rom_mem[v.base + r * v.w + c];
                if (dx >= 0 && dx < 320 && dy >= 0 && dy < 240 && d != 8'h00) begin
                    e.addr = 19'(dy * 320 + dx);
                    e.data = d;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic drive_start(input vec_t v);
        bus.spr_x    = 10'(v.x);
        bus.spr_y    = 10'(v.y);
        bus.spr_w    = 9'(v.w);
        bus.spr_h    = 9'(v.h);
        bus.spr_base = fb_addr_t'(v.base);
`ifdef HFLIP_EN
        bus.flip     = v.flip;
`endif
        bus.start    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int s, guard;
        bit busy_bad;
        load_rom(v);
        build_expect(v);
        wr_count  = 0;
        first_cyc = -1;
        tick();
        drive_start(v);
        s = cyc;
        tick();
        bus.start = 1'b0;
        guard    = 0;
        busy_bad = 1'b0;
        while (bus.done !== 1'b1 && guard < 2000) begin
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (v.poke && guard == 2) begin
                bus.start = 1'b1;
                bus.spr_x = 10'd0;
                bus.spr_w = 9'd2;
                bus.spr_h = 9'd1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            guard++;
        end
        bus.start = 1'b0;
        check({v.name, "_done_latency"}, cyc - s, v.exp_done);
        check({v.name, "_busy_during"}, busy_bad, 0);
        check({v.name, "_busy_at_done"}, bus.busy, 0);
        tick();
        check({v.name, "_done_one_cycle"}, bus.done, 0);
        repeat (3) tick();
        check({v.name, "_write_count"}, wr_count, v.exp_writes);
        check({v.name, "_missing_writes"}, sb.size(), 0);
        if (v.exp_first != 0) check({v.name, "_first_write"}, first_cyc - s, v.exp_first);
    endtask

    initial begin
        //            name          x    y    w  h  base pat fill hole flip poke wr done first
        vt[0] = '{"basic",        10,  20,  4, 2, 100, 1'b0, 5, -1,  1'b0, 1'b0, 8,  11, 3};
        vt[1] = '{"hole",         10,  20,  4, 2, 100, 1'b0, 5, 101, 1'b0, 1'b0, 7,  11, 3};
        vt[2] = '{"bl_corner",    -2,  238, 4, 4, 200, 1'b0, 5, -1,  1'b0, 1'b0, 4,  19, 5};
        vt[3] = '{"w_zero",       0,   0,   0, 5, 0,   1'b0, 5, -1,  1'b0, 1'b0, 0,  2,  0};
        vt[4] = '{"h_zero",       0,   0,   3, 0, 0,   1'b0, 5, -1,  1'b0, 1'b0, 0,  2,  0};
        vt[5] = '{"right_clip",   318, 0,   4, 2, 300, 1'b1, 0, -1,  1'b0, 1'b0, 4,  11, 3};
        vt[6] = '{"offscreen",    -5,  -3,  3, 3, 0,   1'b0, 5, -1,  1'b0, 1'b0, 0,  12, 0};
        vt[7] = '{"single",       0,   0,   1, 1, 10,  1'b0, 9, -1,  1'b0, 1'b0, 1,  4,  3};
        vt[8] = '{"br_corner",    316, 236, 8, 8, 300, 1'b1, 0, -1,  1'b0, 1'b0, 16, 67, 3};
        vt[9] = '{"start_busy",   10,  20,  4, 2, 100, 1'b0, 5, -1,  1'b0, 1'b1, 8,  11, 3};
`ifdef HFLIP_EN
        vt[10] = '{"flip",        0,   0,   3, 1, 49,  1'b1, 0, -1,  1'b1, 1'b0, 3,  6,  3};
`endif

        bus.start    = 1'b0;
        bus.spr_x    = 10'd0;
        bus.spr_y    = 10'd0;
        bus.spr_w    = 9'd0;
        bus.spr_h    = 9'd0;
        bus.spr_base = 19'd0;
`ifdef HFLIP_EN
        bus.flip     = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'h00;

        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_rom_addr", bus.rom_addr, 0);
        check("reset_fb_we", bus.fb_we, 0);
        check("reset_fb_addr", bus.fb_addr, 0);
        check("reset_fb_data", bus.fb_data, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < NV; i++) run_vec(vt[i]);

        // Reset while the third pixel is being written.
        load_rom(vt[0]);
        build_expect(vt[0]);
        wr_count  = 0;
        first_cyc = -1;
        tick();
        drive_start(vt[0]);
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2;
        check("midrst_we_before", bus.fb_we, 1);
        rst = 1'b1;
        #1;
        check("midrst_we_dropped", bus.fb_we, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rom_addr", bus.rom_addr, 0);
        check("midrst_writes_before", wr_count, 3);
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("midrst_no_late_writes", wr_count, 3);
        check("midrst_idle_busy", bus.busy, 0);
        run_vec(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
